// File: rtl/nibble_serial_subtractor_pkg.sv
// nibble_serial_subtractor_pkg: shared state encoding, nibble width and index sizing.
package nibble_serial_subtractor_pkg;
  localparam int NIBBLE_W = 4;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic int idx_w(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction
endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// nibble_serial_subtractor_if: operand and result handshakes of the serial subtractor.
interface nibble_serial_subtractor_if #(parameter int NIBBLES = 4);
  import nibble_serial_subtractor_pkg::*;
  localparam int W = NIBBLE_W * NIBBLES;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         overflow;
  modport master (output in_valid, a, b, bin, out_ready,
                  input  in_ready, out_valid, diff, bout, overflow);
  modport slave  (input  in_valid, a, b, bin, out_ready,
                  output in_ready, out_valid, diff, bout, overflow);
endinterface

// File: rtl/nibble_serial_subtractor_cla4_slice.sv
// cla4_slice: 4-bit carry-lookahead adder slice with fully expanded carries.
module cla4_slice (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;
  always_comb begin
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    s    = p ^ c[3:0];
    co   = c[4];
  end
endmodule

// File: rtl/nibble_serial_subtractor.sv
// nibble_serial_subtractor: computes a - b - bin one nibble per clock as a + ~b + ~bin.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic rst_n,
  nibble_serial_subtractor_if.slave bus
);
  localparam int W  = NIBBLE_W * NIBBLES;
  localparam int IW = idx_w(NIBBLES);
  state_t          state;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_r;
  logic [W-1:0]    nb_r;
  logic [W-1:0]    diff_r;
  logic            bout_r;
  logic            ovf_r;
  logic [3:0]      x;
  logic [3:0]      y;
  logic [3:0]      s;
  logic            co;
  logic            last;
  assign x    = a_r[NIBBLE_W*idx +: NIBBLE_W];
  assign y    = nb_r[NIBBLE_W*idx +: NIBBLE_W];
  assign last = idx == IW'(NIBBLES - 1);
  cla4_slice u_slice (.x(x), .y(y), .ci(carry), .s(s), .co(co));
  // The carry register doubles as the nibble-0 carry-in, seeded with ~bin on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_r    <= '0;
      nb_r   <= '0;
      diff_r <= '0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          a_r   <= bus.a;
          nb_r  <= ~bus.b;
          carry <= ~bus.bin;
          idx   <= '0;
          state <= RUN;
        end
        RUN: begin
          diff_r[NIBBLE_W*idx +: NIBBLE_W] <= s;
          carry <= co;
          idx   <= idx + 1'b1;
          if (last) begin
            bout_r <= ~co;
            ovf_r  <= (a_r[W-1] ~^ nb_r[W-1]) & (s[3] ^ a_r[W-1]);
            state  <= DONE;
          end
        end
        DONE: if (bus.out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.in_ready  = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb_nibble_serial_subtractor: directed and random checks against an arithmetic reference model.
module tb_nibble_serial_subtractor;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int passed = 0;
  nibble_serial_subtractor_if #(.NIBBLES(NIBBLES)) bus ();
  nibble_serial_subtractor #(.NIBBLES(NIBBLES)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    int sd;
    logic [W-1:0] d;
    logic bo, ov;
    sd = int'($signed(a)) - int'($signed(b)) - int'(bin);
    d  = W'(int'(a) - int'(b) - int'(bin));
    bo = int'(a) < int'(b) + int'(bin);
    ov = (sd > (2**(W-1)) - 1) || (sd < -(2**(W-1)));
    return {bo, ov, d};
  endfunction

  task automatic wait_result(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic bin, input bit release_it);
    logic [W+1:0] e;
    int n;
    e = model(a, b, bin);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_diff"}, bus.diff, e[W-1:0]);
    chk({tag, "_bout"}, bus.bout, e[W+1]);
    chk({tag, "_ovf"}, bus.overflow, e[W]);
    if (release_it) begin
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk({tag, "_idle"}, {bus.out_valid, bus.in_ready}, 2'b01);
    end
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    issue(a, b, bin);
    wait_result(tag, a, b, bin, 1'b1);
  endtask

  initial begin
    logic [W-1:0] ra, rb, hd;
    logic rbin, hb, ho;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_state", {bus.in_ready, bus.out_valid, bus.diff, bus.bout, bus.overflow}, {2'b10, 16'h0, 2'b00});
    rst_n = 1'b1;
    @(negedge clk);
    op("one", 16'h0001, 16'h0000, 1'b0);
    op("neg1", 16'h0000, 16'h0001, 1'b0);
    op("ovf", 16'h8000, 16'h0001, 1'b0);
    op("bin", 16'h1234, 16'h1234, 1'b1);
    op("hold_idle", 16'h5555, 16'h1111, 1'b0);
    chk("diff_held_idle", bus.diff, 16'h4444);
    for (int i = 0; i < 12; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rbin = 1'($urandom);
      op($sformatf("rand%0d", i), ra, rb, rbin);
    end
    issue(16'h7FFF, 16'hFFFF, 1'b0);
    wait_result("bp1", 16'h7FFF, 16'hFFFF, 1'b0, 1'b0);
    hd = bus.diff;
    hb = bus.bout;
    ho = bus.overflow;
    bus.in_valid = 1'b1;
    bus.a = 16'h0100;
    bus.b = 16'h0ABC;
    bus.bin = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i), {bus.out_valid, bus.in_ready, bus.diff, bus.bout, bus.overflow},
          {2'b10, hd, hb, ho});
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_idle", {bus.out_valid, bus.in_ready}, 2'b01);
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_result("bp2", 16'h0100, 16'h0ABC, 1'b1, 1'b1);
    issue(16'h1111, 16'h0000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_partial", {bus.out_valid, bus.in_ready, bus.diff[7:0]}, {2'b00, 8'h11});
    rst_n = 1'b0;
    #1;
    chk("mid_rst", {bus.out_valid, bus.in_ready, bus.diff}, {2'b01, 16'h0});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {bus.out_valid, bus.in_ready}, 2'b01);
    op("post_rst", 16'h00FF, 16'h0100, 1'b0);
    chk("post_rst_value", {bus.bout, bus.diff}, {1'b1, 16'hFFFF});
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
